rs_age_pool: RTL and testbench
==============================

RS_AGE_POOL -- requirements
Module: rs_age_pool

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries (2..32).
REQ-002 SHALL have parameter TAG_W, default 4, meaning ROB tag width; tag 0 means "operand ready".
REQ-003 SHALL have parameter DATA_W, default 32, meaning operand, imm and pc width.
REQ-004 SHALL have parameter NUM_CDB, default 2, meaning number of result-broadcast channels (1..4).
REQ-005 SHALL have port clk, input, 1, meaning single system clock, all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port rdy, input, 1, meaning global enable; low freezes all state.
REQ-008 SHALL have port flush, input, 1, meaning branch-mispredict clear.
REQ-009 SHALL have the allocation group: in_valid in 1; in_ready out 1; in_vj and in_vk in DATA_W each; in_qj and in_qk in TAG_W each; in_op in 8 ({optype,opcode}); in_dest in TAG_W; in_pc and in_imm in DATA_W each.
REQ-010 SHALL have the broadcast group: cdb_valid in NUM_CDB; cdb_tag in NUM_CDB*TAG_W; cdb_data in NUM_CDB*DATA_W; channel c occupies slice c.
REQ-011 SHALL have the issue group: out_valid out 1; out_ready in 1; out_vj, out_vk, out_imm and out_pc out DATA_W each; out_op out 8; out_dest out TAG_W.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1), meaning number of occupied entries.

Function
REQ-013 SHALL drive in_ready high iff at least one entry is free at the start of the cycle; a slot freed in the same cycle is not reusable until the next cycle.
REQ-014 SHALL allocate on the edge where rdy, in_valid and in_ready are all high and flush is low, using the lowest-index free entry.
REQ-015 SHALL ignore in_valid when in_ready is low; no entry is overwritten.
REQ-016 SHALL, for each busy entry operand with Q≠0, match against every channel where cdb_valid[c] is high and cdb_tag[c]==Q, then load V=cdb_data[c] and set Q=0.
REQ-017 SHALL apply a match on an allocating operand to in_qj/in_qk in the same cycle (bypass), so the stored Q is 0 and V is the broadcast data.
REQ-018 SHALL resolve multiple channels carrying the same tag to the lowest channel index.
REQ-019 SHALL never match cdb_tag==0.
REQ-020 SHALL make an entry eligible when it is busy with Qj==0 and Qk==0, evaluated on registered state; an entry allocated or woken this cycle is eligible on the next cycle, at the earliest.
REQ-021 SHALL select the oldest eligible entry by allocation order, not by index (age matrix or equivalent); ties are impossible.
REQ-022 SHALL hold an output register: when out_valid is low or out_ready is high and an eligible entry exists, move that entry into the register on the edge, free it, and set out_valid=1.
REQ-023 SHALL clear out_valid on the edge when out_ready is high and no eligible entry exists.
REQ-024 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL give out_* a 1-cycle latency from eligibility to out_valid when the output register is empty; back-to-back issue is 1 per cycle with out_ready held high.
REQ-026 SHALL update count every edge as count + alloc − move; count never exceeds DEPTH and never underflows.
REQ-027 SHALL, on flush with rdy high, free all entries, clear out_valid and reset age state on that edge; flush overrides allocate, broadcast and issue.
REQ-028 SHALL, with rdy low, hold all registers unchanged, including entries, out_* and count; broadcasts and allocations are dropped; in_ready and out_valid still reflect held state.

Reset
REQ-029 SHALL, while rst_n is low and independent of clk, make every entry free, out_valid=0, count=0 and age state empty; out data registers are zero.
REQ-030 SHALL reset on assertion mid-operation immediately, discarding in-flight entries, and resume normal operation on the first rising edge after deassertion.

Verification
REQ-031 SHALL be covered: allocate dest=3, qj=0, qk=0, vj=5, vk=7 with out_ready=1 -> two edges later, out_valid=1, out_dest=3, out_vj=5, out_vk=7, and count returns to 0.
REQ-032 SHALL be covered: allocate A (dest=1, qj=5), B (dest=2, qj=5), then cdb0 tag=5 data=0x11 -> A issues first, then B, both with out_vj=0x11.
REQ-033 SHALL be covered: allocate with qk=6 while cdb1 tag=6 data=0xAB and cdb0 tag=6 data=0xCD -> stored Vk=0xCD and Qk=0 (bypass, lowest channel wins).
REQ-034 SHALL be covered: fill 8 entries with out_ready=0 -> in_ready=0 and count=8; a 9th in_valid is ignored; release out_ready for 1 cycle -> in_ready high on the following cycle.
REQ-035 SHALL be covered: out_valid=1, out_ready=0 with 3 eligible entries, then assert flush -> next edge has out_valid=0, count=0 and in_ready=1.
REQ-036 SHALL be covered: rdy=0 for 3 cycles during a cdb broadcast -> no state change, the tag stays pending; rst_n pulse mid-run -> count=0 and out_valid=0 asynchronously.

Source files
------------

// File: rtl/rs_age_pool.sv
// rs_age_pool: reservation-station pool with oldest-first issue.
//
// Purpose
//   Holds up to DEPTH decoded instructions while their source operands are
//   outstanding. Result broadcasts (CDB) wake pending operands. Once both
//   operands of an entry are ready, the entry becomes eligible. The oldest
//   eligible entry, by allocation order, moves into a single output register.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rdy                        global enable; low freezes every register
//   flush                      mispredict clear; empties the pool and output
//   in_valid / in_ready        allocation handshake
//   in_vj/in_vk, in_qj/in_qk   operand values and producer tags (tag 0 = ready)
//   in_op, in_dest             {optype,opcode} and destination ROB tag
//   in_pc, in_imm              instruction pc and immediate
//   cdb_valid/tag/data         NUM_CDB broadcast channels; channel c uses slice c
//   out_valid / out_ready      issue handshake on the output register
//   out_vj/vk/imm/pc/op/dest   contents of the issued entry
//   count                      number of occupied entries
module rs_age_pool #(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_vj,
  input  logic [DATA_W-1:0]          in_vk,
  input  logic [TAG_W-1:0]           in_qj,
  input  logic [TAG_W-1:0]           in_qk,
  input  logic [7:0]                 in_op,
  input  logic [TAG_W-1:0]           in_dest,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_vj,
  output logic [DATA_W-1:0]          out_vk,
  output logic [DATA_W-1:0]          out_imm,
  output logic [DATA_W-1:0]          out_pc,
  output logic [7:0]                 out_op,
  output logic [TAG_W-1:0]           out_dest,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]  busy;
  logic [TAG_W-1:0]  qj     [DEPTH];
  logic [TAG_W-1:0]  qk     [DEPTH];
  logic [DATA_W-1:0] vj     [DEPTH];
  logic [DATA_W-1:0] vk     [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] imm_q  [DEPTH];
  logic [7:0]        op_q   [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  // older[i][j] set means entry j was allocated before entry i.
  logic [DEPTH-1:0]  older  [DEPTH];

  logic [DEPTH-1:0]  wj_hit, wk_hit;
  logic [DATA_W-1:0] wj_data [DEPTH];
  logic [DATA_W-1:0] wk_data [DEPTH];
  logic              bj_hit, bk_hit;
  logic [DATA_W-1:0] bj_data, bk_data;

  logic [DEPTH-1:0]  elig, pick;
  logic              any_elig;
  logic [IW-1:0]     free_idx, sel_idx;
  logic              free_found;
  logic              alloc, move;

  // Returns {hit, data}. Scanning from the top channel down lets the lowest
  // matching channel overwrite the result, so it wins. Tag 0 never matches.
  function automatic logic [DATA_W:0] snoop(
    input logic [TAG_W-1:0]          q,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  t,
    input logic [NUM_CDB*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (q != '0 && v[c] && t[c*TAG_W +: TAG_W] == q) begin
        r = {1'b1, d[c*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  // Operand wake-up for stored entries, plus bypass for the incoming entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wj_hit[i], wj_data[i]} = snoop(qj[i], cdb_valid, cdb_tag, cdb_data);
      {wk_hit[i], wk_data[i]} = snoop(qk[i], cdb_valid, cdb_tag, cdb_data);
    end
    {bj_hit, bj_data} = snoop(in_qj, cdb_valid, cdb_tag, cdb_data);
    {bk_hit, bk_data} = snoop(in_qk, cdb_valid, cdb_tag, cdb_data);
  end

  // Lowest-index free slot, taken from registered occupancy only, so a slot
  // freed by this cycle's issue is not reused until the next cycle.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !free_found) begin
        free_idx   = IW'(i);
        free_found = 1'b1;
      end
    end
  end

  // An eligible entry is picked when no other eligible entry is older than it.
  // Allocation order is total, so exactly one entry can be picked.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = busy[i] && (qj[i] == '0) && (qk[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pick[i] = elig[i] && ((elig & older[i]) == '0);
    end
    any_elig = |elig;
    sel_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick[i]) sel_idx = IW'(i);
    end
  end

  assign in_ready = ~&busy;
  assign alloc    = rdy && !flush && in_valid && in_ready;
  assign move     = rdy && !flush && any_elig && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      out_valid <= 1'b0;
      count     <= '0;
      out_vj    <= '0;
      out_vk    <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
      out_op    <= '0;
      out_dest  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        older[i]  <= '0;
        qj[i]     <= '0;
        qk[i]     <= '0;
        vj[i]     <= '0;
        vk[i]     <= '0;
        pc_q[i]   <= '0;
        imm_q[i]  <= '0;
        op_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        out_valid <= 1'b0;
        count     <= '0;
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wj_hit[i]) begin
            qj[i] <= '0;
            vj[i] <= wj_data[i];
          end
          if (wk_hit[i]) begin
            qk[i] <= '0;
            vk[i] <= wk_data[i];
          end
        end
        if (alloc) begin
          busy[free_idx]   <= 1'b1;
          qj[free_idx]     <= bj_hit ? '0 : in_qj;
          vj[free_idx]     <= bj_hit ? bj_data : in_vj;
          qk[free_idx]     <= bk_hit ? '0 : in_qk;
          vk[free_idx]     <= bk_hit ? bk_data : in_vk;
          pc_q[free_idx]   <= in_pc;
          imm_q[free_idx]  <= in_imm;
          op_q[free_idx]   <= in_op;
          dest_q[free_idx] <= in_dest;
          // New entry is younger than everything present; stale bits in its
          // column left by a previous occupant are cleared in the other rows.
          for (int i = 0; i < DEPTH; i++) begin
            if (IW'(i) == free_idx) older[i] <= busy;
            else                    older[i][free_idx] <= 1'b0;
          end
        end
        if (move) begin
          busy[sel_idx] <= 1'b0;
          out_valid     <= 1'b1;
          out_vj        <= vj[sel_idx];
          out_vk        <= vk[sel_idx];
          out_imm       <= imm_q[sel_idx];
          out_pc        <= pc_q[sel_idx];
          out_op        <= op_q[sel_idx];
          out_dest      <= dest_q[sel_idx];
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        count <= count + CW'(alloc) - CW'(move);
      end
    end
  end

endmodule

// File: tb/tb_rs_age_pool.sv
// tb_rs_age_pool: self-checking bench for rs_age_pool.
//
// The reference model keeps the pool as a queue in allocation order, so the
// oldest ready instruction is simply the first ready element. Entries moved to
// the output register are pushed to a scoreboard; a monitor pops and compares
// whenever the DUT completes an issue handshake.
module tb_rs_age_pool;

  localparam int DEPTH   = 8;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int NUM_CDB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_vj, in_vk, in_pc, in_imm;
  logic [TAG_W-1:0]  in_qj, in_qk, in_dest;
  logic [7:0]        in_op;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic [DATA_W-1:0] out_vj, out_vk, out_imm, out_pc;
  logic [7:0]        out_op;
  logic [TAG_W-1:0]  out_dest;
  logic [$clog2(DEPTH+1)-1:0] count;

  rs_age_pool #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .in_op(in_op), .in_dest(in_dest), .in_pc(in_pc), .in_imm(in_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vj(out_vj), .out_vk(out_vk), .out_imm(out_imm), .out_pc(out_pc),
    .out_op(out_op), .out_dest(out_dest), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]  qj, qk, dest;
    logic [DATA_W-1:0] vj, vk, pc, imm;
    logic [7:0]        op;
  } ent_t;

  ent_t pool[$];
  ent_t sb[$];
  bit   m_ov;
  int   tests = 0;
  int   fails = 0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Broadcast lookup as the rules state it: lowest matching channel, tag 0 never matches.
  function automatic void resolve(input logic [TAG_W-1:0] q, input logic [DATA_W-1:0] v,
                                  output logic [TAG_W-1:0] qo, output logic [DATA_W-1:0] vo);
    bit found;
    found = 0;
    qo = q;
    vo = v;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (!found && q != 0 && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == q) begin
        found = 1;
        qo = 0;
        vo = cdb_data[c*DATA_W +: DATA_W];
      end
    end
  endfunction

  // Predicts the effect of the coming clock edge from the inputs now driven.
  task automatic modelStep();
    int idx;
    bit take, mv;
    ent_t e;
    logic [TAG_W-1:0]  tq;
    logic [DATA_W-1:0] tv;
    if (!rdy) return;
    if (flush) begin
      pool.delete();
      sb.delete();
      m_ov = 0;
      return;
    end
    idx = -1;
    for (int i = 0; i < pool.size(); i++)
      if (idx < 0 && pool[i].qj == 0 && pool[i].qk == 0) idx = i;
    take = in_valid && (pool.size() < DEPTH);
    mv   = (idx >= 0) && (!m_ov || out_ready);
    for (int i = 0; i < pool.size(); i++) begin
      e = pool[i];
      resolve(e.qj, e.vj, tq, tv); e.qj = tq; e.vj = tv;
      resolve(e.qk, e.vk, tq, tv); e.qk = tq; e.vk = tv;
      pool[i] = e;
    end
    if (mv) begin
      sb.push_back(pool[idx]);
      pool.delete(idx);
      m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (take) begin
      e.dest = in_dest; e.op = in_op; e.pc = in_pc; e.imm = in_imm;
      resolve(in_qj, in_vj, tq, tv); e.qj = tq; e.vj = tv;
      resolve(in_qk, in_vk, tq, tv); e.qk = tq; e.vk = tv;
      pool.push_back(e);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".count"},     32'(count),     32'(pool.size()));
    checkEq({tag, ".in_ready"},  32'(in_ready),  32'(pool.size() < DEPTH));
    checkEq({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
  endtask

  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle();
    rdy = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_vj = 0; in_vk = 0; in_qj = 0; in_qk = 0; in_op = 0; in_dest = 0;
    in_pc = 0; in_imm = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic pulseReset();
    in_valid = 0; out_ready = 0; cdb_valid = 0; flush = 0; rdy = 1;
    #2 rst_n = 1'b0;
    #1;
    checkEq("async_rst.count",     32'(count),     32'd0);
    checkEq("async_rst.out_valid", 32'(out_valid), 32'd0);
    pool.delete();
    sb.delete();
    m_ov = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst");
  endtask

  // Monitor: every completed issue handshake must match the next scoreboard entry.
  initial begin
    ent_t x;
    forever begin
      @(negedge clk);
      if (rst_n && rdy && !flush && out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL issue_unexpected: got dest=%0d vj=0x%0h, expected no issue", out_dest, out_vj);
        end else begin
          x = sb.pop_front();
          if (out_dest !== x.dest || out_vj !== x.vj || out_vk !== x.vk ||
              out_op !== x.op || out_pc !== x.pc || out_imm !== x.imm) begin
            fails++;
            $display("[TB] FAIL issue_data: got dest=%0d vj=0x%0h vk=0x%0h op=0x%0h pc=0x%0h imm=0x%0h, expected dest=%0d vj=0x%0h vk=0x%0h op=0x%0h pc=0x%0h imm=0x%0h",
                     out_dest, out_vj, out_vk, out_op, out_pc, out_imm,
                     x.dest, x.vj, x.vk, x.op, x.pc, x.imm);
          end
        end
      end
    end
  end

  initial begin
    idle();
    m_ov = 0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("reset.count",     32'(count),     32'd0);
    checkEq("reset.out_valid", 32'(out_valid), 32'd0);
    checkEq("reset.in_ready",  32'(in_ready),  32'd1);
    checkEq("reset.out_dest",  32'(out_dest),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ready instruction flows straight through.
    out_ready = 1; in_valid = 1; in_dest = 3; in_vj = 5; in_vk = 7;
    in_op = 8'h21; in_pc = 32'h100; in_imm = 32'h4;
    applyStimulus("d31_alloc");
    in_valid = 0;
    applyStimulus("d31_move");
    checkEq("d31.out_valid", 32'(out_valid), 32'd1);
    checkEq("d31.out_dest",  32'(out_dest),  32'd3);
    checkEq("d31.out_vj",    out_vj,         32'd5);
    checkEq("d31.out_vk",    out_vk,         32'd7);
    applyStimulus("d31_drain");
    checkEq("d31.count", 32'(count), 32'd0);

    // Two waiters on the same tag wake together; the older issues first.
    in_valid = 1; in_qj = 5; in_dest = 1; in_vk = 32'h22;
    applyStimulus("d32_allocA");
    in_dest = 2;
    applyStimulus("d32_allocB");
    in_valid = 0; in_qj = 0;
    cdb_valid = 2'b01; cdb_tag[3:0] = 5; cdb_data[31:0] = 32'h11;
    applyStimulus("d32_wake");
    cdb_valid = 0;
    applyStimulus("d32_issueA");
    checkEq("d32.first_dest", 32'(out_dest), 32'd1);
    checkEq("d32.first_vj",   out_vj,        32'h11);
    applyStimulus("d32_issueB");
    checkEq("d32.second_dest", 32'(out_dest), 32'd2);
    checkEq("d32.second_vj",   out_vj,        32'h11);
    applyStimulus("d32_drain");

    // Bypass on allocation with the same tag on both channels.
    in_valid = 1; in_qj = 0; in_qk = 6; in_vj = 1; in_vk = 0; in_dest = 4;
    cdb_valid = 2'b11;
    cdb_tag  = {4'd6, 4'd6};
    cdb_data = {32'hAB, 32'hCD};
    applyStimulus("d33_alloc");
    in_valid = 0; in_qk = 0; cdb_valid = 0;
    applyStimulus("d33_move");
    checkEq("d33.out_valid", 32'(out_valid), 32'd1);
    checkEq("d33.out_vk",    out_vk,         32'hCD);
    applyStimulus("d33_drain");

    // Fill the pool with the output stalled.
    out_ready = 0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1; in_dest = 4'(k + 1); in_vj = 32'(k); in_vk = 32'(k + 100);
      applyStimulus("d34_fill");
    end
    checkEq("d34.full_count",    32'(count),    32'd8);
    checkEq("d34.full_in_ready", 32'(in_ready), 32'd0);
    in_dest = 15;
    applyStimulus("d34_ignored");
    checkEq("d34.ignored_count", 32'(count), 32'd8);
    in_valid = 0; out_ready = 1;
    applyStimulus("d34_release");
    out_ready = 0;
    checkEq("d34.in_ready_after", 32'(in_ready), 32'd1);

    // Flush with a stalled output and several eligible entries.
    checkEq("d35.pre_out_valid", 32'(out_valid), 32'd1);
    flush = 1;
    applyStimulus("d35_flush");
    flush = 0;
    checkEq("d35.out_valid", 32'(out_valid), 32'd0);
    checkEq("d35.count",     32'(count),     32'd0);
    checkEq("d35.in_ready",  32'(in_ready),  32'd1);

    // Broadcast while frozen is lost; the tag stays pending.
    idle();
    in_valid = 1; in_qj = 9; in_dest = 6;
    applyStimulus("d36_alloc6");
    in_qj = 10; in_dest = 7;
    applyStimulus("d36_alloc7");
    in_valid = 0; in_qj = 0;
    rdy = 0; cdb_valid = 2'b01; cdb_tag[3:0] = 9; cdb_data[31:0] = 32'h55;
    repeat (3) applyStimulus("d36_frozen");
    rdy = 1; cdb_valid = 0; out_ready = 1;
    applyStimulus("d36_after1");
    applyStimulus("d36_after2");
    checkEq("d36.pending_out_valid", 32'(out_valid), 32'd0);
    checkEq("d36.pending_count",     32'(count),     32'd2);
    cdb_valid = 2'b01;
    applyStimulus("d36_wake");
    cdb_valid = 0;
    applyStimulus("d36_issue");
    checkEq("d36.out_dest", 32'(out_dest), 32'd6);
    checkEq("d36.out_vj",   out_vj,        32'h55);
    pulseReset();

    // Randomised traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 59) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_qj    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      in_qk    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      in_vj    = $urandom;
      in_vk    = $urandom;
      in_pc    = $urandom;
      in_imm   = $urandom;
      in_op    = 8'($urandom);
      in_dest  = 4'($urandom);
      for (int c = 0; c < NUM_CDB; c++) begin
        cdb_valid[c] = 1'($urandom_range(0, 1));
        cdb_tag[c*TAG_W +: TAG_W]   = 4'($urandom_range(0, 6));
        cdb_data[c*DATA_W +: DATA_W] = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0) && rdy && !flush;
      applyStimulus("rand");
      if (n == 700) pulseReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
